// File: rtl/lsu_pkg.sv
// Shared encodings and bus payload type for the load/store unit bus adapter.
package lsu_pkg;

    localparam int unsigned XLEN            = 32;
    localparam int unsigned TIMEOUT_DEFAULT = 255;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    typedef struct packed {
        logic            we;
        logic [XLEN-1:0] addr;
        logic [3:0]      be;
        logic [XLEN-1:0] wdata;
    } bus_req_t;

endpackage

// File: rtl/lsu_lane.sv
// Alignment check, byte enables and store-lane placement from address offset and size.
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [1:0]      addr_lo_i,
    input  logic [1:0]      size_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic            misaligned_c,
    output logic [3:0]      be_c,
    output logic [XLEN-1:0] wdata_c
);

    // Sub-word stores are replicated so the addressed lanes always carry the data.
    always_comb begin
        misaligned_c = 1'b0;
        be_c         = 4'b1111;
        wdata_c      = wdata_i;
        case (size_i)
            SZ_HALF: begin
                misaligned_c = addr_lo_i[0];
                be_c         = 4'b0011 << addr_lo_i;
                wdata_c      = {2{wdata_i[15:0]}};
            end
            SZ_BYTE: begin
                be_c    = 4'b0001 << addr_lo_i;
                wdata_c = {4{wdata_i[7:0]}};
            end
            default: misaligned_c = (addr_lo_i != 2'b00);
        endcase
    end

endmodule

// File: rtl/lsu_bus.sv
// Load/store unit to simple valid/ready bus adapter with core stall, alignment check and timeout.
module lsu_bus
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mem_req,
    input  logic            mem_we,
    input  logic [1:0]      memwritefrmt,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    output logic            stall,
    output logic [XLEN-1:0] rdata,
    output logic            misaligned,
    output logic            bus_err,
    output logic            bus_valid,
    output logic            bus_we,
    output logic [XLEN-1:0] bus_addr,
    output logic [3:0]      bus_be,
    output logic [XLEN-1:0] bus_wdata,
    input  logic            bus_ready,
    input  logic            bus_rvalid,
    input  logic [XLEN-1:0] bus_rdata
);

    localparam int unsigned     CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]      off_q, off_d;
    bus_req_t        bus_q, bus_d;
    logic            bus_valid_q, bus_valid_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            misaligned_q, misaligned_d;
    logic            bus_err_q, bus_err_d;

    logic            lane_mis;
    logic [3:0]      lane_be;
    logic [XLEN-1:0] lane_wdata;

    lsu_lane u_lane (
        .addr_lo_i    (addr[1:0]),
        .size_i       (memwritefrmt),
        .wdata_i      (wdata),
        .misaligned_c (lane_mis),
        .be_c         (lane_be),
        .wdata_c      (lane_wdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            off_q        <= '0;
            bus_q        <= '0;
            bus_valid_q  <= 1'b0;
            rdata_q      <= '0;
            misaligned_q <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            off_q        <= off_d;
            bus_q        <= bus_d;
            bus_valid_q  <= bus_valid_d;
            rdata_q      <= rdata_d;
            misaligned_q <= misaligned_d;
            bus_err_q    <= bus_err_d;
        end
    end

    // Next state; completion on the bus takes priority over a timeout in the same cycle.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        off_d        = off_q;
        bus_d        = bus_q;
        rdata_d      = rdata_q;
        misaligned_d = 1'b0;
        bus_err_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (mem_req) begin
                    if (lane_mis) begin
                        state_d      = ST_DONE;
                        misaligned_d = 1'b1;
                    end else begin
                        state_d     = ST_REQ;
                        cnt_d       = '0;
                        off_d       = addr[1:0];
                        bus_d.we    = mem_we;
                        bus_d.addr  = {addr[XLEN-1:2], 2'b00};
                        bus_d.be    = lane_be;
                        bus_d.wdata = lane_wdata;
                    end
                end
            end
            ST_REQ: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (bus_ready) begin
                    state_d = bus_q.we ? ST_DONE : ST_WAIT;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = ST_DONE;
                    bus_err_d = 1'b1;
                    rdata_d   = '0;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (bus_rvalid) begin
                    state_d = ST_DONE;
                    rdata_d = bus_rdata >> {off_q, 3'b000};
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = ST_DONE;
                    bus_err_d = 1'b1;
                    rdata_d   = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        bus_valid_d = (state_d == ST_REQ);
        if (state_d != ST_REQ) begin
            bus_d = '0;
        end
    end

    assign stall      = mem_req && (state_q != ST_DONE);
    assign rdata      = rdata_q;
    assign misaligned = misaligned_q;
    assign bus_err    = bus_err_q;
    assign bus_valid  = bus_valid_q;
    assign bus_we     = bus_q.we;
    assign bus_addr   = bus_q.addr;
    assign bus_be     = bus_q.be;
    assign bus_wdata  = bus_q.wdata;

endmodule

// File: tb/tb_lsu_bus.sv
// Directed bench for lsu_bus: table of single accesses plus wait, timeout and reset sequences.
module tb_lsu_bus;

    logic        clk;
    logic        rst;
    logic        mem_req, mem_req_t;
    logic        mem_we;
    logic [1:0]  memwritefrmt;
    logic [31:0] addr, wdata;
    logic        bus_ready, bus_ready_t, bus_rvalid;
    logic [31:0] bus_rdata;

    logic        stall, misaligned, bus_err, bus_valid, bus_we;
    logic [31:0] rdata, bus_addr, bus_wdata;
    logic [3:0]  bus_be;

    logic        stall_t, misaligned_t, bus_err_t, bus_valid_t, bus_we_t;
    logic [31:0] rdata_t, bus_addr_t, bus_wdata_t;
    logic [3:0]  bus_be_t;

    int tests = 0;
    int fails = 0;

    lsu_bus dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we),
        .memwritefrmt(memwritefrmt), .addr(addr), .wdata(wdata),
        .stall(stall), .rdata(rdata), .misaligned(misaligned), .bus_err(bus_err),
        .bus_valid(bus_valid), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_ready(bus_ready), .bus_rvalid(bus_rvalid),
        .bus_rdata(bus_rdata)
    );

    lsu_bus #(.TIMEOUT_CYCLES(4)) dut_to (
        .clk(clk), .rst(rst), .mem_req(mem_req_t), .mem_we(mem_we),
        .memwritefrmt(memwritefrmt), .addr(addr), .wdata(wdata),
        .stall(stall_t), .rdata(rdata_t), .misaligned(misaligned_t), .bus_err(bus_err_t),
        .bus_valid(bus_valid_t), .bus_we(bus_we_t), .bus_addr(bus_addr_t), .bus_be(bus_be_t),
        .bus_wdata(bus_wdata_t), .bus_ready(bus_ready_t), .bus_rvalid(bus_rvalid),
        .bus_rdata(bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [1:0]  sz;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        mis;
        logic [3:0]  be;
        logic [31:0] bw;
        logic [31:0] rdat;
        logic [3:0]  stalls;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One access on the main instance; bus_rvalid rises from cycle rv_cycle onward.
    task automatic run_access(input logic we, input logic [1:0] sz, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] rd, input int rv_cycle,
                              output int stalls, output logic vseen, output logic [31:0] baddr,
                              output logic [31:0] bwd, output logic [3:0] be, output logic bwe,
                              output logic mis, output logic err, output logic [31:0] rdat,
                              output logic done_ok);
        mem_req = 1'b1; mem_we = we; memwritefrmt = sz; addr = a; wdata = wd;
        bus_rdata = rd; bus_ready = 1'b1; bus_rvalid = (rv_cycle == 0);
        stalls = 0; vseen = 1'b0; done_ok = 1'b0;
        baddr = '0; bwd = '0; be = '0; bwe = 1'b0; mis = 1'b0; err = 1'b0; rdat = '0;
        for (int c = 0; c < 40 && !done_ok; c++) begin
            @(negedge clk);
            if (stall) stalls++;
            if (bus_valid) begin
                vseen = 1'b1; baddr = bus_addr; bwd = bus_wdata; be = bus_be; bwe = bus_we;
            end
            if (!stall) begin
                done_ok = 1'b1; mis = misaligned; err = bus_err; rdat = rdata;
            end
            tick();
            bus_rvalid = (c + 1 >= rv_cycle);
        end
        mem_req = 1'b0;
        bus_rvalid = 1'b0;
    endtask

    int          st, nvalid;
    logic        vs, bwe_s, mis_s, err_s, ok;
    logic [31:0] ba_s, bw_s, rd_s;
    logic [3:0]  be_s;

    initial begin
        vecs[0]  = '{1'b1, 2'b00, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0, 4'b1111, 32'hDEADBEEF, 32'h00000000, 4'd2};
        vecs[1]  = '{1'b1, 2'b10, 32'h103, 32'h000000AB, 32'h0, 1'b0, 4'b1000, 32'hABABABAB, 32'h00000000, 4'd2};
        vecs[2]  = '{1'b0, 2'b00, 32'h200, 32'h0, 32'hCAFEF00D, 1'b0, 4'b1111, 32'h0, 32'hCAFEF00D, 4'd3};
        vecs[3]  = '{1'b0, 2'b10, 32'h201, 32'h0, 32'h11223344, 1'b0, 4'b0010, 32'h0, 32'h00112233, 4'd3};
        vecs[4]  = '{1'b0, 2'b01, 32'h202, 32'h0, 32'h12345678, 1'b0, 4'b1100, 32'h0, 32'h00001234, 4'd3};
        vecs[5]  = '{1'b1, 2'b01, 32'h102, 32'h0000BEEF, 32'h0, 1'b0, 4'b1100, 32'hBEEFBEEF, 32'h00001234, 4'd2};
        vecs[6]  = '{1'b0, 2'b00, 32'h101, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h00001234, 4'd1};
        vecs[7]  = '{1'b0, 2'b01, 32'h103, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h00001234, 4'd1};
        vecs[8]  = '{1'b1, 2'b11, 32'h304, 32'h01020304, 32'h0, 1'b0, 4'b1111, 32'h01020304, 32'h00001234, 4'd2};
        vecs[9]  = '{1'b0, 2'b10, 32'h303, 32'h0, 32'hA5000000, 1'b0, 4'b1000, 32'h0, 32'h000000A5, 4'd3};
        vecs[10] = '{1'b1, 2'b01, 32'h101, 32'h00001111, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h000000A5, 4'd1};
        vecs[11] = '{1'b1, 2'b10, 32'h100, 32'h12345677, 32'h0, 1'b0, 4'b0001, 32'h77777777, 32'h000000A5, 4'd2};

        rst = 1'b0; mem_req = 1'b0; mem_req_t = 1'b0; mem_we = 1'b0; memwritefrmt = 2'b00;
        addr = '0; wdata = '0; bus_ready = 1'b0; bus_ready_t = 1'b0; bus_rvalid = 1'b0;
        bus_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_misaligned", 32'(misaligned), 32'h0);
        chk("rst_bus_err", 32'(bus_err), 32'h0);
        chk("rst_bus_valid", 32'(bus_valid), 32'h0);
        chk("rst_bus_we", 32'(bus_we), 32'h0);
        chk("rst_bus_be", 32'(bus_be), 32'h0);
        chk("rst_bus_addr", bus_addr, 32'h0);
        chk("rst_bus_wdata", bus_wdata, 32'h0);
        tick();
        rst = 1'b1;
        tick();

        for (int i = 0; i < 12; i++) begin
            run_access(vecs[i].we, vecs[i].sz, vecs[i].addr, vecs[i].wd, vecs[i].rd, 0,
                       st, vs, ba_s, bw_s, be_s, bwe_s, mis_s, err_s, rd_s, ok);
            $display("[TB] vector %0d addr %h", i, vecs[i].addr);
            chk("vec_done", 32'(ok), 32'h1);
            chk("vec_stalls", 32'(st), 32'(vecs[i].stalls));
            chk("vec_bus_valid_seen", 32'(vs), 32'(!vecs[i].mis));
            chk("vec_misaligned", 32'(mis_s), 32'(vecs[i].mis));
            chk("vec_bus_err", 32'(err_s), 32'h0);
            chk("vec_rdata", rd_s, vecs[i].rdat);
            if (!vecs[i].mis) begin
                chk("vec_bus_addr", ba_s, {vecs[i].addr[31:2], 2'b00});
                chk("vec_bus_be", 32'(be_s), 32'(vecs[i].be));
                chk("vec_bus_wdata", bw_s, vecs[i].bw);
                chk("vec_bus_we", 32'(bwe_s), 32'(vecs[i].we));
            end
            @(negedge clk);
            chk("vec_idle_bus_zero", 32'(bus_valid) | 32'(bus_be) | bus_addr | bus_wdata, 32'h0);
            chk("vec_misaligned_pulse_gone", 32'(misaligned), 32'h0);
            tick();
        end

        // Halfword load with three empty wait cycles before read data.
        run_access(1'b0, 2'b01, 32'h102, 32'h0, 32'h12345678, 5,
                   st, vs, ba_s, bw_s, be_s, bwe_s, mis_s, err_s, rd_s, ok);
        chk("lh_wait_done", 32'(ok), 32'h1);
        chk("lh_wait_stalls", 32'(st), 32'd6);
        chk("lh_wait_rdata", rd_s, 32'h00001234);
        chk("lh_wait_be", 32'(be_s), 32'b1100);
        tick();

        // Timeout instance: a good load first, then a load the bus never accepts.
        mem_req_t = 1'b1; mem_we = 1'b0; memwritefrmt = 2'b00; addr = 32'h400;
        bus_ready_t = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'h55AA55AA;
        ok = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk);
            if (!stall_t) ok = 1'b1;
            tick();
        end
        chk("to_first_load_done", 32'(ok), 32'h1);
        chk("to_first_load_rdata", rdata_t, 32'h55AA55AA);
        bus_rvalid = 1'b0; bus_ready_t = 1'b0;
        st = 0; nvalid = 0; ok = 1'b0; err_s = 1'b0; rd_s = 32'hFFFFFFFF;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk);
            if (stall_t) st++;
            if (bus_valid_t) nvalid++;
            if (!stall_t) begin
                ok = 1'b1; err_s = bus_err_t; rd_s = rdata_t;
            end
            tick();
        end
        mem_req_t = 1'b0;
        chk("to_done", 32'(ok), 32'h1);
        chk("to_req_cycles", 32'(nvalid), 32'd4);
        chk("to_stalls", 32'(st), 32'd5);
        chk("to_bus_err", 32'(err_s), 32'h1);
        chk("to_rdata", rd_s, 32'h0);
        @(negedge clk);
        chk("to_bus_err_pulse", 32'(bus_err_t), 32'h0);
        chk("to_bus_valid_off", 32'(bus_valid_t), 32'h0);
        tick();

        // Reset while a load waits for data; late read data must be ignored.
        mem_req = 1'b1; mem_we = 1'b0; memwritefrmt = 2'b00; addr = 32'h500;
        bus_ready = 1'b1; bus_rvalid = 1'b0;
        tick();
        tick();
        #2 rst = 1'b0;
        @(negedge clk);
        chk("rstw_stall", 32'(stall), 32'h1);
        chk("rstw_rdata", rdata, 32'h0);
        chk("rstw_bus_valid", 32'(bus_valid), 32'h0);
        tick();
        rst = 1'b1; mem_req = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'hFFFFFFFF;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rstw_late_rdata", rdata, 32'h0);
            chk("rstw_late_stall", 32'(stall), 32'h0);
            chk("rstw_late_valid", 32'(bus_valid), 32'h0);
            tick();
        end
        bus_rvalid = 1'b0; mem_req = 1'b1;
        @(negedge clk);
        chk("rstw_stall_follows_req", 32'(stall), 32'h1);
        #1 mem_req = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
